// File: rtl/brid_alloc.sv
// Branch-snapshot id allocator between decode and rename: grants ids to branches in
// program order from a circular window, releases them at commit, truncates/flushes on redirect.
module brid_alloc #(
    parameter int dwd  = 4,
    parameter int cwd  = 4,
    parameter int brsz = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [dwd-1:0]           valid,
    input  logic [dwd-1:0]           branch,
    input  logic [dwd-1:0]           take,
    output logic [dwd-1:0]           grant,
    output logic [dwd*8-1:0]         brid,
    input  logic [cwd-1:0]           com_br,
    input  logic                     redir,
    input  logic [7:0]               redir_brid,
    output logic [6:0]               head,
    output logic [$clog2(brsz):0]    count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(brsz);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic [dwd-1:0] alloc_bit;
    logic [AW-1:0]  slot_idx;
    logic [AW-1:0]  redir_idx;
    logic [AW-1:0]  mp_dist;
    logic           scan_ok;
    int             grant_n;
    int             alloc_n;
    int             rel_raw;
    int             rel_n;

    // In-order grant scan: the first slot that cannot proceed blocks every later slot.
    always_comb begin
        grant    = '0;
        brid     = '0;
        scan_ok  = !redir;
        grant_n  = 0;
        slot_idx = tail_reg;
        for (int i = 0; i < dwd; i++) begin
            if (scan_ok && valid[i] && (!branch[i] || (int'(count_reg) + grant_n < brsz))) begin
                grant[i] = 1'b1;
                if (branch[i]) begin
                    slot_idx         = tail_reg + AW'(grant_n);
                    brid[i*8 +: 8]   = {1'b1, 7'(slot_idx)};
                    grant_n          = grant_n + 1;
                end
            end else begin
                scan_ok = 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < dwd; gi++) begin : g_alloc
        assign alloc_bit[gi] = take[gi] & grant[gi] & branch[gi];
    end

    always_comb begin
        alloc_n = 0;
        for (int i = 0; i < dwd; i++) begin
            if (alloc_bit[i]) alloc_n = alloc_n + 1;
        end
        rel_raw = 0;
        for (int j = 0; j < cwd; j++) begin
            if (com_br[j]) rel_raw = rel_raw + 1;
        end
        rel_n = (rel_raw > int'(count_reg)) ? int'(count_reg) : rel_raw;
    end

    // Redirect distance is taken against the pre-commit head; commits still retire.
    assign redir_idx = redir_brid[AW-1:0];
    assign mp_dist   = redir_idx - head_reg;

    always_comb begin
        head_next  = head_reg + AW'(rel_n);
        tail_next  = tail_reg + AW'(alloc_n);
        count_next = count_reg + CW'(alloc_n) - CW'(rel_n);
        if (redir) begin
            if (redir_brid[7]) begin
                tail_next  = redir_idx + 1'b1;
                count_next = CW'(mp_dist) + CW'(1) - CW'(rel_n);
            end else begin
                tail_next  = head_next;
                count_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign head  = 7'(head_reg);
    assign count = count_reg;
    assign full  = (count_reg == CW'(brsz));
    assign empty = (count_reg == '0);

    always @(posedge clk) begin
        if (rst) begin
            assert ((take & ~grant) == '0)
                else $error("brid_alloc: take outside grant prefix");
            assert (rel_raw <= int'(count_reg))
                else $error("brid_alloc: commit releases more ids than live");
            if (redir && redir_brid[7]) begin
                assert (CW'(mp_dist) < count_reg && (redir_brid[6:0] >> AW) == 7'd0)
                    else $error("brid_alloc: mispredict id outside live window");
            end
        end
    end
endmodule

// File: tb/tb_brid_alloc.sv
// Scoreboard bench for brid_alloc: the driver queues hand-computed expectations per
// transaction, a monitor checks grant/brid mid-cycle and head/count/full/empty a cycle later.
module tb_brid_alloc;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid, branch, take, grant, com_br;
    logic [31:0] brid;
    logic        redir;
    logic [7:0]  redir_brid;
    logic [6:0]  head;
    logic [4:0]  count;
    logic        full, empty;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0]  g;
        logic [31:0] b;
        logic [6:0]  h;
        logic [4:0]  c;
    } exp_t;

    exp_t cb_q[$];
    exp_t st_q[$];

    brid_alloc dut (
        .clk(clk), .rst(rst), .valid(valid), .branch(branch), .take(take),
        .grant(grant), .brid(brid), .com_br(com_br), .redir(redir),
        .redir_brid(redir_brid), .head(head), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] v, input logic [3:0] br, input logic [3:0] cb,
                         input logic rd, input logic [7:0] rb,
                         input logic [3:0] eg, input logic [31:0] eb,
                         input logic [6:0] eh, input logic [4:0] ec);
        exp_t e;
        @(posedge clk); #1;
        valid = v; branch = br; take = eg; com_br = cb; redir = rd; redir_brid = rb;
        e.g = eg; e.b = eb; e.h = eh; e.c = ec;
        cb_q.push_back(e);
        $display("txn v=%b br=%b com=%b redir=%b rb=%h -> grant %b brid %h head %0d count %0d",
                 v, br, cb, rd, rb, eg, eb, eh, ec);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid = '0; branch = '0; take = '0; com_br = '0; redir = 1'b0; redir_brid = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && (cb_q.size() != 0 || st_q.size() != 0); i++) begin
            @(negedge clk); #1;
        end
        chk("drain", 32'(cb_q.size() + st_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] pk4(input int t);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'h80 + 8'(t);     b1 = 8'h80 + 8'(t + 1);
        b2 = 8'h80 + 8'(t + 2); b3 = 8'h80 + 8'(t + 3);
        return {b3, b2, b1, b0};
    endfunction

    // Monitor: state of the previous transaction first, then this cycle's grant/brid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (st_q.size() != 0) begin
                e = st_q.pop_front();
                chk("head",  32'(head),  32'(e.h));
                chk("count", 32'(count), 32'(e.c));
                chk("full",  32'(full),  32'(e.c == 5'd16));
                chk("empty", 32'(empty), 32'(e.c == 5'd0));
            end
            if (cb_q.size() != 0) begin
                e = cb_q.pop_front();
                chk("grant", 32'(grant), 32'(e.g));
                chk("brid",  brid,       e.b);
                st_q.push_back(e);
            end
        end
    end

    initial begin
        rst = 1'b0;
        valid = '0; branch = '0; take = '0; com_br = '0; redir = 1'b0; redir_brid = '0;
        repeat (3) @(negedge clk);
        chk("rst_head",  32'(head),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        rst = 1'b1;

        // mixed decode group: branches in slots 1 and 3
        apply(4'b1111, 4'b1010, 4'b0000, 1'b0, 8'h00, 4'b1111, 32'h81008000, 7'd0, 5'd2);
        for (int k = 0; k < 3; k++)
            apply(4'b1111, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b1111, pk4(2 + 4*k), 7'd0, 5'(6 + 4*k));
        apply(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h00, 4'b0001, 32'h0000008E, 7'd0, 5'd15);
        // one free slot left: only slot 0 gets it
        apply(4'b1111, 4'b0011, 4'b0000, 1'b0, 8'h00, 4'b0001, 32'h0000008F, 7'd0, 5'd16);
        apply(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h00, 4'b0000, 32'h00000000, 7'd0, 5'd16);
        apply(4'b1111, 4'b1000, 4'b0000, 1'b0, 8'h00, 4'b0111, 32'h00000000, 7'd0, 5'd16);
        // release two, then allocate across the wrap
        apply(4'b0000, 4'b0000, 4'b0011, 1'b0, 8'h00, 4'b0000, 32'h00000000, 7'd2, 5'd14);
        apply(4'b0011, 4'b0011, 4'b0000, 1'b0, 8'h00, 4'b0011, 32'h00008180, 7'd2, 5'd16);
        // release while full does not free a slot in the same cycle
        apply(4'b0001, 4'b0001, 4'b0001, 1'b0, 8'h00, 4'b0000, 32'h00000000, 7'd3, 5'd15);
        apply(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h00, 4'b0001, 32'h00000082, 7'd3, 5'd16);
        // full flush, then build live window 3..9
        apply(4'b1111, 4'b1111, 4'b0000, 1'b1, 8'h00, 4'b0000, 32'h00000000, 7'd3, 5'd0);
        apply(4'b1111, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b1111, 32'h86858483, 7'd3, 5'd4);
        apply(4'b0111, 4'b0111, 4'b0000, 1'b0, 8'h00, 4'b0111, 32'h00898887, 7'd3, 5'd7);
        // mispredict at id 5 with one commit
        apply(4'b1111, 4'b1111, 4'b0001, 1'b1, 8'h85, 4'b0000, 32'h00000000, 7'd4, 5'd2);
        apply(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h00, 4'b0001, 32'h00000086, 7'd4, 5'd3);
        apply(4'b0111, 4'b0111, 4'b0000, 1'b0, 8'h00, 4'b0111, 32'h00898887, 7'd4, 5'd6);
        // non-branch flush with two commits
        apply(4'b0000, 4'b0000, 4'b0011, 1'b1, 8'h00, 4'b0000, 32'h00000000, 7'd6, 5'd0);
        apply(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h00, 4'b0001, 32'h00000086, 7'd6, 5'd1);
        apply(4'b1111, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b1111, 32'h8A898887, 7'd6, 5'd5);
        apply(4'b1111, 4'b0110, 4'b0000, 1'b0, 8'h00, 4'b1111, 32'h008C8B00, 7'd6, 5'd7);
        idle();
        drain();

        // asynchronous reset away from any clock edge, with allocation requests pending
        @(posedge clk); #1;
        valid = 4'b1111; branch = 4'b1111; take = '0;
        #2 rst = 1'b0;
        #1;
        chk("async_head",  32'(head),  32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        repeat (2) @(negedge clk);
        valid = '0; branch = '0;
        rst = 1'b1;
        apply(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'h00, 4'b0001, 32'h00000080, 7'd0, 5'd1);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
